// File: rtl/sms4_pkg.sv
// rtl/sms4_pkg.sv - shared SMS4 state enum, round constants and GF arithmetic helpers
package sms4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } sms4_state_e;

    localparam int SMS4_ROUNDS = 32;

    // L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24
    localparam int L_ROT_A = 2;
    localparam int L_ROT_B = 10;
    localparam int L_ROT_C = 18;
    localparam int L_ROT_D = 24;

    // S-box: A * inv(A*x ^ C) ^ C in GF(2^8) mod x^8+x^7+x^6+x^5+x^4+x^2+1
    localparam logic [8:0] SBOX_POLY   = 9'h1F5;
    localparam logic [7:0] SBOX_AROW   = 8'hA7;
    localparam logic [7:0] SBOX_ACONST = 8'hD3;

    // Inversion field: GF(2^4) mod x^4+x+1, GF((2^4)^2) mod y^2+y+lambda
    localparam logic [3:0] GF4_RED   = 4'h3;
    localparam logic [3:0] GF_LAMBDA = 4'hC;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Linear part of the S-box affine map; row i is 0xA7 rotated left by i
    function automatic logic [7:0] sm4_affine(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) y[i] = ^(x & rotl8(SBOX_AROW, i));
        return y;
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] s;
        p = 4'h0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[2:0], 1'b0} ^ (s[3] ? GF4_RED : 4'h0);
        end
        return p;
    endfunction

    // a^14 is the inverse in GF(2^4); 0 maps to 0
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a8, a4), a2);
    endfunction

    // Composite element {h, l} = h*y + l
    function automatic logic [7:0] gfc_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh, hl, lh, ll;
        hh = gf16_mul(a[7:4], b[7:4]);
        hl = gf16_mul(a[7:4], b[3:0]);
        lh = gf16_mul(a[3:0], b[7:4]);
        ll = gf16_mul(a[3:0], b[3:0]);
        return {hh ^ hl ^ lh, ll ^ gf16_mul(GF_LAMBDA, hh)};
    endfunction

    function automatic logic [7:0] gfc_inv(input logic [7:0] a);
        logic [3:0] d, di;
        d  = gf16_mul(GF_LAMBDA, gf16_mul(a[7:4], a[7:4])) ^ gf16_mul(a[7:4], a[3:0])
           ^ gf16_mul(a[3:0], a[3:0]);
        di = gf16_inv(d);
        return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
    endfunction

    // Bit matrix stored as columns: m[8i+7:8i] is the image of bit i
    function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) if (x[i]) y = y ^ m[8*i +: 8];
        return y;
    endfunction

    // Polynomial basis -> composite basis: column i is beta^i for a root beta of SBOX_POLY
    function automatic logic [63:0] iso_fwd_map();
        logic [7:0]  beta, p, acc;
        logic [63:0] m;
        logic        found;
        beta  = 8'h02;
        found = 1'b0;
        m     = '0;
        for (int c = 2; c < 256; c++) begin
            p   = 8'h01;
            acc = 8'h00;
            for (int k = 0; k < 9; k++) begin
                if (SBOX_POLY[k]) acc = acc ^ p;
                p = gfc_mul(p, 8'(c));
            end
            if (!found && acc == 8'h00) begin
                beta  = 8'(c);
                found = 1'b1;
            end
        end
        p = 8'h01;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = p;
            p = gfc_mul(p, beta);
        end
        return m;
    endfunction

    function automatic logic [63:0] iso_bwd_map(input logic [63:0] fwd);
        logic [63:0] m;
        m = '0;
        for (int j = 0; j < 8; j++)
            for (int v = 0; v < 256; v++)
                if (lin_map(fwd, 8'(v)) == 8'(1 << j)) m[8*j +: 8] = 8'(v);
        return m;
    endfunction

endpackage

// File: rtl/sms4_sbox.sv
// rtl/sms4_sbox.sv - SMS4 byte S-box, inversion done in GF((2^4)^2)
module sms4_sbox
    import sms4_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [63:0] ISO_FWD = iso_fwd_map();
    localparam logic [63:0] ISO_BWD = iso_bwd_map(ISO_FWD);

    logic [7:0] u;
    logic [7:0] v;

    // affine in, map to composite field, invert, map back, affine out
    always_comb begin
        u    = lin_map(ISO_FWD, sm4_affine(din) ^ SBOX_ACONST);
        v    = gfc_inv(u);
        dout = sm4_affine(lin_map(ISO_BWD, v)) ^ SBOX_ACONST;
    end

endmodule

// File: rtl/sms4_dec.sv
// rtl/sms4_dec.sv - SMS4 iterative decrypt engine; SMS4_ENC_EN adds enc input for encrypt key order
module sms4_dec
    import sms4_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef SMS4_ENC_EN
    input  logic         enc,
`endif
    input  logic [127:0] din,
    input  logic [31:0]  rk_in,
    output logic [4:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout
);
    sms4_state_e  state_q, state_d;
    logic [4:0]   r_q, r_d;
    logic [127:0] x_q, x_d;
    logic [127:0] dout_q, dout_d;
    logic         done_q, done_d;
    logic [31:0]  sbox_in, sbox_out, t_out;
`ifdef SMS4_ENC_EN
    logic         enc_q, enc_d;
`endif

    // round input X1 ^ X2 ^ X3 ^ rk
    assign sbox_in = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_in;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sms4_sbox u_sbox (
            .din  (sbox_in[8*i +: 8]),
            .dout (sbox_out[8*i +: 8])
        );
    end

    assign t_out = sbox_out ^ rotl32(sbox_out, L_ROT_A) ^ rotl32(sbox_out, L_ROT_B)
                 ^ rotl32(sbox_out, L_ROT_C) ^ rotl32(sbox_out, L_ROT_D);

    assign done = done_q;
    assign dout = dout_q;

    // status outputs: key index counts down for decrypt, zero outside RUN
    always_comb begin
        busy   = (state_q == ST_RUN);
        rk_idx = 5'd0;
        if (state_q == ST_RUN) begin
`ifdef SMS4_ENC_EN
            rk_idx = enc_q ? r_q : ~r_q;
`else
            rk_idx = ~r_q;
`endif
        end
    end

    // next state: load on start, one round per RUN cycle, publish reversed words in FIN
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        x_d     = x_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
`ifdef SMS4_ENC_EN
        enc_d   = enc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    r_d     = 5'd0;
                    x_d     = din;
`ifdef SMS4_ENC_EN
                    enc_d   = enc;
`endif
                end
            end
            ST_RUN: begin
                x_d = {x_q[95:0], x_q[127:96] ^ t_out};
                r_d = r_q + 5'd1;
                if (r_q == 5'(SMS4_ROUNDS - 1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                dout_d  = {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]};
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= 5'd0;
            x_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
`ifdef SMS4_ENC_EN
            enc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            x_q     <= x_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
`ifdef SMS4_ENC_EN
            enc_q   <= enc_d;
`endif
        end
    end

endmodule

// File: tb/tb_sms4_dec.sv
// tb/tb_sms4_dec.sv - scoreboard bench for sms4_dec with the standard SMS4 vector
module tb_sms4_dec;

    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         enc;
    logic [127:0] din;
    logic [31:0]  rk_in;
    logic [4:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [127:0] dout;

    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         exp_q[$];
    exp_t         mon_e;
    logic         done_prev = 1'b0;

    logic [7:0]   sbox_t[256];
    logic [7:0]   inv_t[256];
    logic [31:0]  rk_mem[32];

    sms4_dec dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
`ifdef SMS4_ENC_EN
        .enc    (enc),
`endif
        .din    (din),
        .rk_in  (rk_in),
        .rk_idx (rk_idx),
        .busy   (busy),
        .done   (done),
        .dout   (dout)
    );

    assign rk_in = rk_mem[rk_idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = s[7] ? ({s[6:0], 1'b0} ^ 8'hF5) : {s[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] aff(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] row;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            row  = 8'hA7;
            row  = (row << i) | (row >> (8 - i));
            y[i] = ^(x & row);
        end
        return y;
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] b);
        return {sbox_t[b[31:24]], sbox_t[b[23:16]], sbox_t[b[15:8]], sbox_t[b[7:0]]};
    endfunction

    // reference S-box by brute-force inversion in the polynomial basis, then key expansion
    task automatic build_model();
        logic [31:0] k[36];
        logic [31:0] fk[4];
        logic [31:0] ck, b;
        fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        inv_t[0] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) inv_t[a] = 8'(c);
        for (int x = 0; x < 256; x++) sbox_t[x] = aff(inv_t[aff(8'(x)) ^ 8'hD3]) ^ 8'hD3;
        for (int i = 0; i < 4; i++) k[i] = KEY[127 - 32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4*i) * 7), 8'((4*i + 1) * 7), 8'((4*i + 2) * 7), 8'((4*i + 3) * 7)};
            b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ b ^ rl(b, 13) ^ rl(b, 23);
            rk_mem[i] = k[i+4];
        end
    endtask

    task automatic push_exp(input logic [127:0] data, input int when);
        exp_t e;
        e.data = data;
        e.cyc  = when;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0, "drain_timeout", 128'(exp_q.size()), 128'd0);
        @(negedge clk);
    endtask

    // one block: optional ignored start pulse at RUN cycle pulse_at, optional reset at RUN cycle rst_at
    task automatic run_block(input logic [127:0] d, input logic [127:0] want, input bit fwd,
                             input int pulse_at, input int rst_at);
        int t0;
        bit aborted;
        aborted = 1'b0;
        @(posedge clk); #1;
        din = d;
        start = 1'b1;
        t0 = cyc;
        if (rst_at < 0) push_exp(want, t0 + 34);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check(busy == 1'b1, "busy_in_run", 128'(busy), 128'd1);
            check(rk_idx == (fwd ? 5'(k) : 5'(31 - k)), "rk_idx_trace", 128'(rk_idx),
                  fwd ? 128'(k) : 128'(31 - k));
            if (k == pulse_at) begin
                start = 1'b1;
                din = ~d;
            end
            if (k == pulse_at + 1) start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check(busy == 1'b0, "abort_busy", 128'(busy), 128'd0);
                check(dout == 128'd0, "abort_dout", dout, 128'd0);
                check(rk_idx == 5'd0, "abort_rk_idx", 128'(rk_idx), 128'd0);
                check(done == 1'b0, "abort_done", 128'(done), 128'd0);
                repeat (40) @(negedge clk);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            check(busy == 1'b0, "busy_after_32", 128'(busy), 128'd0);
            drain();
        end
    endtask

    // monitor: every done pulse must match the oldest expectation, data and cycle
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check(done_prev == 1'b0, "done_width", 128'(done_prev), 128'd0);
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_done", dout, 128'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check(dout == mon_e.data, "dout", dout, mon_e.data);
                check(cyc == mon_e.cyc, "done_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
        done_prev = (done === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        rst = 1'b1;
        start = 1'b0;
        enc = 1'b0;
        din = '0;
        build_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(busy == 1'b0, "reset_busy", 128'(busy), 128'd0);
        check(done == 1'b0, "reset_done", 128'(done), 128'd0);
        check(dout == 128'd0, "reset_dout", dout, 128'd0);
        check(rk_idx == 5'd0, "reset_rk_idx", 128'(rk_idx), 128'd0);

        check(sbox_t[0] == 8'hD6, "model_sbox0", 128'(sbox_t[0]), 128'hD6);
        check(sbox_t[1] == 8'h90, "model_sbox1", 128'(sbox_t[1]), 128'h90);
        check(rk_mem[0] == 32'hf12186f9, "model_rk0", 128'(rk_mem[0]), 128'hf12186f9);
        check(rk_mem[31] == 32'h9124a012, "model_rk31", 128'(rk_mem[31]), 128'h9124a012);

        run_block(CT, PT, 1'b0, -1, -1);
        run_block(CT, PT, 1'b0, 10, -1);
        run_block(CT, PT, 1'b0, -1, 20);
        run_block(CT, PT, 1'b0, -1, -1);

        @(posedge clk); #1;
        din = CT;
        start = 1'b1;
        t0 = cyc;
        for (int b = 0; b < 3; b++) push_exp(PT, t0 + 34 + 34 * b);
        repeat (80) @(posedge clk);
        #1 start = 1'b0;
        drain();

`ifdef SMS4_ENC_EN
        enc = 1'b1;
        run_block(PT, CT, 1'b1, -1, -1);
        enc = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
